// File: rtl/ntlm_candidate_gen.sv
// Brute-force candidate enumerator for the NTLM core.
// An odometer walks CHAR_LO..CHAR_HI for every length from min_len to max_len.
module ntlm_candidate_gen #(
  parameter logic [7:0] CHAR_LO = 8'h61,
  parameter logic [7:0] CHAR_HI = 8'h7A,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       min_len,
  input  logic [3:0]       max_len,
  input  logic             ready,
  output logic             valid,
  output logic [0:127]     instr,
  output logic [0:3]       length,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       max_q, max_d;
  logic [7:0]       chr_q [16];
  logic [7:0]       chr_d [16];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry;
  logic [3:0]       lo_len;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 16; i++) chr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      chr_q   <= chr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    chr_d   = chr_q;
    carry   = 1'b0;
    lo_len  = (min_len == 4'd0) ? 4'd1 : min_len;
    unique case (state_q)
      S_RUN: begin
        if (ready) begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          carry = 1'b1;
          for (int i = 0; i < 16; i++) begin
            if (carry && i < int'(len_q)) begin
              if (chr_q[i] == CHAR_HI) begin
                chr_d[i] = CHAR_LO;
              end else begin
                chr_d[i] = chr_q[i] + 8'd1;
                carry    = 1'b0;
              end
            end
          end
          if (carry) begin
            if (len_q < max_q) begin
              len_d = len_q + 4'd1;
              for (int i = 0; i < 16; i++)
                if (i <= int'(len_q)) chr_d[i] = CHAR_LO;
            end else begin
              state_d = S_FIN;
            end
          end
        end
        // Abort drops the pending candidate; an accept on the same edge still counts
        if (stop) begin
          state_d = S_IDLE;
          len_d   = len_q;
          chr_d   = chr_q;
        end
      end
      default: begin
        if (start) begin
          max_d = max_len;
          cnt_d = '0;
          for (int i = 0; i < 16; i++) chr_d[i] = '0;
          if (lo_len > max_len || max_len == 4'd0) begin
            state_d = S_FIN;
            len_d   = '0;
          end else begin
            state_d = S_RUN;
            len_d   = lo_len;
            for (int i = 0; i < 16; i++)
              if (i < int'(lo_len)) chr_d[i] = CHAR_LO;
          end
        end
      end
    endcase
  end

  always_comb begin
    valid  = (state_q == S_RUN);
    busy   = (state_q == S_RUN);
    done   = (state_q == S_FIN);
    length = len_q;
    count  = cnt_q;
    instr  = '0;
    for (int i = 0; i < 16; i++) instr[8*i +: 8] = chr_q[i];
  end

endmodule

// File: tb/tb_ntlm_candidate_gen.sv
// Bench for ntlm_candidate_gen over a three-letter alphabet a..c.
// Expected candidates come from an index-to-digits model queued at start.
module tb_ntlm_candidate_gen;

  localparam logic [7:0] LO = 8'h61;
  localparam logic [7:0] HI = 8'h63;
  localparam int         N  = 3;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         ready = 1'b0;
  logic [3:0]   min_len = '0;
  logic [3:0]   max_len = '0;
  logic         valid;
  logic [0:127] instr;
  logic [0:3]   length;
  logic         busy;
  logic         done;
  logic [31:0]  count;

  ntlm_candidate_gen #(
    .CHAR_LO(LO),
    .CHAR_HI(HI),
    .CNT_W  (32)
  ) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .start  (start),
    .stop   (stop),
    .min_len(min_len),
    .max_len(max_len),
    .ready  (ready),
    .valid  (valid),
    .instr  (instr),
    .length (length),
    .busy   (busy),
    .done   (done),
    .count  (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:127] ins;
    logic [3:0]   len;
  } cand_t;

  typedef struct {
    int mn;
    int mx;
    int exp_cnt;
    int hold_at;
  } vec_t;

  cand_t exp_q[$];
  vec_t  vt[7];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_cands(int mn, int mx);
    int    l0;
    int    tot;
    int    v;
    cand_t c;
    l0 = (mn == 0) ? 1 : mn;
    if (l0 > mx || mx == 0) return;
    for (int l = l0; l <= mx; l++) begin
      tot = 1;
      for (int j = 0; j < l; j++) tot *= N;
      for (int k = 0; k < tot; k++) begin
        c.ins = '0;
        c.len = 4'(l);
        v = k;
        for (int i = 0; i < l; i++) begin
          c.ins[8*i +: 8] = LO + 8'(v % N);
          v = v / N;
        end
        exp_q.push_back(c);
      end
    end
  endtask

  task automatic pop_chk(string nm);
    cand_t c;
    chk({nm, "_avail"}, 128'(exp_q.size() != 0), 128'd1);
    if (exp_q.size() != 0) begin
      c = exp_q.pop_front();
      chk({nm, "_instr"}, instr, c.ins);
      chk({nm, "_len"}, 128'(length), 128'(c.len));
    end
  endtask

  task automatic start_run(int mn, int mx);
    min_len = 4'(mn);
    max_len = 4'(mx);
    exp_q.delete();
    push_cands(mn, mx);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(vec_t v);
    int           iter;
    logic [0:127] snap;
    iter  = 0;
    ready = 1'b1;
    start_run(v.mn, v.mx);
    chk("first_valid", 128'(valid), 128'(v.exp_cnt > 0));
    while (!done && iter < 2000) begin
      if (v.hold_at == iter) begin
        ready = 1'b0;
        snap  = instr;
        repeat (3) begin
          tick();
          chk("hold_valid", 128'(valid), 128'd1);
          chk("hold_instr", instr, snap);
        end
        ready = 1'b1;
      end
      pop_chk("cand");
      tick();
      iter++;
    end
    chk("iters", 128'(iter), 128'(v.exp_cnt));
    chk("done_end", 128'(done), 128'd1);
    chk("count_end", 128'(count), 128'(v.exp_cnt));
    chk("valid_end", 128'(valid), 128'd0);
    chk("busy_end", 128'(busy), 128'd0);
    chk("q_left", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1, 2, 12, 6};
    vt[1] = '{1, 2, 12, -1};
    vt[2] = '{4, 2, 0, -1};
    vt[3] = '{0, 1, 3, -1};
    vt[4] = '{2, 2, 9, -1};
    vt[5] = '{0, 0, 0, -1};
    vt[6] = '{1, 3, 39, -1};

    // reset held with start high
    n_rst   = 1'b0;
    start   = 1'b1;
    min_len = 4'd1;
    max_len = 4'd2;
    repeat (3) tick();
    chk("rst_valid", 128'(valid), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_len", 128'(length), 128'd0);
    chk("rst_instr", instr, 128'd0);
    start = 1'b0;
    n_rst = 1'b1;
    repeat (2) tick();
    chk("idle_valid", 128'(valid), 128'd0);
    chk("idle_busy", 128'(busy), 128'd0);

    for (int t = 0; t < 7; t++) run_vec(vt[t]);

    // stop after five accepts, ready low at the stop edge
    ready = 1'b1;
    start_run(3, 3);
    for (int k = 0; k < 5; k++) begin
      pop_chk("t4");
      tick();
    end
    ready = 1'b0;
    stop  = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid", 128'(valid), 128'd0);
    chk("stop_busy", 128'(busy), 128'd0);
    chk("stop_done", 128'(done), 128'd0);
    chk("stop_count", 128'(count), 128'd5);
    start_run(3, 3);
    pop_chk("restart");
    chk("restart_count", 128'(count), 128'd0);
    chk("restart_busy", 128'(busy), 128'd1);
    ready = 1'b1;
    stop  = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_rdy_count", 128'(count), 128'd1);
    chk("stop_rdy_valid", 128'(valid), 128'd0);
    chk("stop_rdy_busy", 128'(busy), 128'd0);

    // reset while "ca" is on the bus
    ready = 1'b1;
    start_run(1, 2);
    for (int k = 0; k < 5; k++) begin
      pop_chk("t6");
      tick();
    end
    pop_chk("t6_ca");
    n_rst = 1'b0;
    tick();
    chk("mid_rst_valid", 128'(valid), 128'd0);
    chk("mid_rst_len", 128'(length), 128'd0);
    chk("mid_rst_count", 128'(count), 128'd0);
    chk("mid_rst_instr", instr, 128'd0);
    chk("mid_rst_done", 128'(done), 128'd0);
    n_rst = 1'b1;
    repeat (5) begin
      tick();
      chk("post_rst_valid", 128'(valid), 128'd0);
    end
    chk("post_rst_busy", 128'(busy), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
